// File: rtl/conv_window_gen.sv
// conv_window_gen: streams a raster image and emits every full 5x5 window with its coordinates
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic signed [DW-1:0] data_00, data_01, data_02, data_03, data_04,
    output logic signed [DW-1:0] data_10, data_11, data_12, data_13, data_14,
    output logic signed [DW-1:0] data_20, data_21, data_22, data_23, data_24,
    output logic signed [DW-1:0] data_30, data_31, data_32, data_33, data_34,
    output logic signed [DW-1:0] data_40, data_41, data_42, data_43, data_44,
    output logic                 win_valid,
    output logic [4:0]           win_row,
    output logic [4:0]           win_col,
    output logic                 frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 accept, emit, last_col, last_row;
    logic                 win_valid_q;
    logic [4:0]           win_row_q, win_col_q;
    logic signed [DW-1:0] lb_q  [4][IMG_W];
    logic signed [DW-1:0] win_q [5][5];
    logic signed [DW-1:0] win_d [5][5];
    logic signed [DW-1:0] out_q [5][5];
    logic signed [DW-1:0] col_v [5];

    assign pix_ready  = (state_q == FILL) || (state_q == STREAM);
    assign accept     = pix_valid && pix_ready;
    assign last_col   = col_q == CW'(IMG_W - 1);
    assign last_row   = row_q == RW'(IMG_H - 1);
    assign emit       = accept && (row_q >= RW'(4)) && (col_q >= CW'(4));
    assign frame_done = state_q == DONE;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign {data_00, data_01, data_02, data_03, data_04} = {out_q[0][0], out_q[0][1], out_q[0][2], out_q[0][3], out_q[0][4]};
    assign {data_10, data_11, data_12, data_13, data_14} = {out_q[1][0], out_q[1][1], out_q[1][2], out_q[1][3], out_q[1][4]};
    assign {data_20, data_21, data_22, data_23, data_24} = {out_q[2][0], out_q[2][1], out_q[2][2], out_q[2][3], out_q[2][4]};
    assign {data_30, data_31, data_32, data_33, data_34} = {out_q[3][0], out_q[3][1], out_q[3][2], out_q[3][3], out_q[3][4]};
    assign {data_40, data_41, data_42, data_43, data_44} = {out_q[4][0], out_q[4][1], out_q[4][2], out_q[4][3], out_q[4][4]};

    // frame sequencing and raster position tracking; start only counts in IDLE
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FILL;
                col_d   = '0;
                row_d   = '0;
            end
            FILL, STREAM: if (accept) begin
                col_d = last_col ? '0 : col_q + 1'b1;
                row_d = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
                if (state_q == FILL && row_q == RW'(4) && col_q == '0) state_d = STREAM;
                if (state_q == STREAM && last_col && last_row) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // next window: the four buffered rows above plus the incoming pixel form the new right column
    always_comb begin
        for (int k = 0; k < 4; k++) col_v[k] = lb_q[k][col_q];
        col_v[4] = pix_in;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][4] = col_v[r];
        end
    end

    // line buffers age one row per column slot; window shifts left on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 3; k++) lb_q[k][col_q] <= lb_q[k+1][col_q];
            lb_q[3][col_q] <= pix_in;
            win_q <= win_d;
        end
    end

    // control state and registered window outputs, which only change when a window is emitted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            out_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= emit;
            if (emit) begin
                out_q     <= win_d;
                win_row_q <= 5'(row_q - RW'(4));
                win_col_q <= 5'(col_q - CW'(4));
            end
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: random-stimulus bench comparing emitted windows against a stored image model
module tb_conv_window_gen;
    localparam int W = 28;
    localparam int H = 28;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_valid = 1'b0;
    logic signed [31:0] pix_in = '0;
    logic pix_ready, win_valid, frame_done;
    logic [4:0] win_row, win_col;
    logic signed [31:0] d [5][5];
    logic signed [31:0] img [H][W];
    int qr[$], qc[$];
    int ncmp = 0, nerr = 0, nwin = 0;
    logic done_seen = 1'b0, got_done = 1'b0;
    logic signed [31:0] hold00, hold44, first00, first04, first40, first44, last00, last44;
    logic [4:0] hold_row, hold_col;

    conv_window_gen dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .data_00(d[0][0]), .data_01(d[0][1]), .data_02(d[0][2]), .data_03(d[0][3]), .data_04(d[0][4]),
        .data_10(d[1][0]), .data_11(d[1][1]), .data_12(d[1][2]), .data_13(d[1][3]), .data_14(d[1][4]),
        .data_20(d[2][0]), .data_21(d[2][1]), .data_22(d[2][2]), .data_23(d[2][3]), .data_24(d[2][4]),
        .data_30(d[3][0]), .data_31(d[3][1]), .data_32(d[3][2]), .data_33(d[3][3]), .data_34(d[3][4]),
        .data_40(d[4][0]), .data_41(d[4][1]), .data_42(d[4][2]), .data_43(d[4][3]), .data_44(d[4][4]),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int wr, wc;
        logic is_last;
        @(negedge clk);
        if (done_seen) begin
            chk("ready_after_done", pix_ready, 0);
            done_seen = 1'b0;
        end
        if (win_valid) begin
            if (qr.size() == 0) chk("spurious_win", 1, 0);
            else begin
                wr = qr.pop_front();
                wc = qc.pop_front();
                chk("win_row", win_row, wr);
                chk("win_col", win_col, wc);
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        chk($sformatf("data_%0d%0d", r, c), d[r][c], img[wr+r][wc+c]);
                is_last = (wr == H - 5) && (wc == W - 5);
                chk("frame_done_on_win", frame_done, is_last);
                if (is_last) begin
                    done_seen = 1'b1;
                    got_done  = 1'b1;
                    last00 = d[0][0];
                    last44 = d[4][4];
                end
                if (nwin == 0) begin
                    first00 = d[0][0];
                    first04 = d[0][4];
                    first40 = d[4][0];
                    first44 = d[4][4];
                end
                nwin++;
            end
            hold00 = d[0][0];
            hold44 = d[4][4];
            hold_row = win_row;
            hold_col = win_col;
        end else begin
            chk("hold_data_00", d[0][0], hold00);
            chk("hold_data_44", d[4][4], hold44);
            chk("hold_win_row", win_row, hold_row);
            chk("hold_win_col", win_col, hold_col);
            chk("frame_done_idle", frame_done, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        qr.delete();
        qc.delete();
        done_seen = 1'b0;
        hold00 = '0;
        hold44 = '0;
        hold_row = '0;
        hold_col = '0;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_data_00", d[0][0], 0);
        chk("rst_data_22", d[2][2], 0);
        chk("rst_data_44", d[4][4], 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
    endtask

    task automatic run_frame(input int mode, input logic gaps, input int abort_at, input logic poke);
        int k, gap, cyc;
        logic v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (mode == 0) ? 32'(r * W + c) : (mode == 1) ? -32'sd1 : 32'($urandom);
        nwin = 0;
        got_done = 1'b0;
        if (poke) begin
            repeat (5) begin
                tick();
                chk("idle_ready", pix_ready, 0);
                pix_valid = 1'b1;
                pix_in = 32'($urandom);
            end
        end
        tick();
        pix_valid = 1'b0;
        start = 1'b1;
        k = 0;
        gap = 0;
        cyc = 0;
        while (k < H * W && !(abort_at > 0 && k == abort_at)) begin
            tick();
            start = poke && (k == 400);
            v = (gap == 0);
            pix_valid = v;
            pix_in = img[k / W][k % W];
            if (v && pix_ready) begin
                if (k / W >= 4 && k % W >= 4) begin
                    qr.push_back(k / W - 4);
                    qc.push_back(k % W - 4);
                end
                k++;
                gap = gaps ? int'($urandom_range(0, 3)) : 0;
            end else if (!v) gap--;
            cyc++;
            if (cyc > 20000) begin
                chk("frame_timeout", cyc, 0);
                break;
            end
        end
        if (abort_at > 0 && k == abort_at) begin
            tick();
            do_reset();
            return;
        end
        cyc = 0;
        do begin
            tick();
            pix_valid = 1'b0;
            start = 1'b0;
            cyc++;
        end while (!done_seen && cyc < 10);
        tick();
        chk("frame_done_seen", got_done, 1);
        chk("win_count", nwin, (H - 4) * (W - 4));
        chk("queue_empty", qr.size(), 0);
        if (mode == 0) begin
            chk("first_data_00", first00, 0);
            chk("first_data_04", first04, 4);
            chk("first_data_40", first40, 112);
            chk("first_data_44", first44, 116);
            chk("last_data_00", last00, 667);
            chk("last_data_44", last44, 783);
        end
    endtask

    initial begin
        do_reset();
        run_frame(0, 1'b0, 0, 1'b0);
        run_frame(0, 1'b1, 0, 1'b0);
        run_frame(0, 1'b0, 300, 1'b0);
        run_frame(0, 1'b0, 0, 1'b0);
        run_frame(1, 1'b1, 0, 1'b0);
        run_frame(2, 1'b1, 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
